// File: rtl/drop_sequencer_pkg.sv
// Shared types and constants for the Connect Four move sequencer.
// Board geometry, player encoding, FSM state encoding and thermometer helpers.
package drop_sequencer_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int MOVES_MAX = NUM_COLS * NUM_ROWS;
    localparam int CELLS     = NUM_COLS * NUM_ROWS;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_UPDATE,
        ST_DRAW,
        ST_NEXT,
        ST_FULL
    } state_t;

    // Number of filled cells in a column, which is also the index of the next free cell.
    function automatic logic [2:0] therm_count(input logic [NUM_ROWS-1:0] therm);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            n = n + {2'b00, therm[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/drop_sequencer_find_vga_row.sv
// Thermometer-to-VGA-row decoder: a column holding N pieces puts its top piece
// on VGA row NUM_ROWS-N (row 0 is the top of the screen).
module find_vga_row
    import drop_sequencer_pkg::*;
(
    input  logic [NUM_ROWS-1:0] therm_i,
    output logic [2:0]          vga_row_o
);

    logic [2:0] filled;

    always_comb begin
        filled    = therm_count(therm_i);
        vga_row_o = (filled == 3'd0) ? 3'd0 : 3'(NUM_ROWS) - filled;
    end

endmodule

// File: rtl/drop_sequencer.sv
// Connect Four move controller: validates a column choice, drops the piece into
// the occupancy/owner maps, issues one VGA draw request and passes the turn.
//
// state  | meaning
// IDLE   | waiting for a move; move_ready high
// CHECK  | column range / full-column check, reject with move_err
// UPDATE | write thermometer and owner bit, latch draw coordinates
// DRAW   | draw_req held until draw_done
// NEXT   | toggle player, bump move count, detect full board
// FULL   | board complete; only new_game or reset leave
module drop_sequencer
    import drop_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [2:0]       move_col,
    output logic             move_ready,
    output logic             move_err,
    output logic             draw_req,
    output logic [2:0]       draw_col,
    output logic [2:0]       draw_row,
    output logic             draw_player,
    input  logic             draw_done,
    output logic             cur_player,
    output logic             board_full,
    output logic [CELLS-1:0] onoff_flat,
    output logic [CELLS-1:0] owner_flat
);

    state_t            state_q, state_d;
    logic [2:0]        col_q, col_d;
    logic [CELLS-1:0]  onoff_q, onoff_d;
    logic [CELLS-1:0]  owner_q, owner_d;
    logic              player_q, player_d;
    logic [5:0]        count_q, count_d;
    logic              draw_req_q, draw_req_d;
    logic [2:0]        draw_col_q, draw_col_d;
    logic [2:0]        draw_row_q, draw_row_d;
    logic              draw_player_q, draw_player_d;
    logic              move_err_q, move_err_d;
    logic              board_full_q, board_full_d;

    logic [NUM_ROWS-1:0] col_therm, col_therm_new;
    logic [NUM_ROWS-1:0] col_owner, col_owner_new;
    logic [2:0]          free_idx;
    logic                col_legal;
    logic [2:0]          new_row;

    // Column selection by compare loop so an out-of-range col_q simply reads as empty.
    always_comb begin
        col_therm = '0;
        col_owner = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == 3'(c)) begin
                col_therm = onoff_q[c*NUM_ROWS +: NUM_ROWS];
                col_owner = owner_q[c*NUM_ROWS +: NUM_ROWS];
            end
        end
    end

    assign col_legal     = (col_q < 3'(NUM_COLS)) && !col_therm[NUM_ROWS-1];
    assign col_therm_new = {col_therm[NUM_ROWS-2:0], 1'b1};
    assign free_idx      = therm_count(col_therm);

    always_comb begin
        col_owner_new = col_owner;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (free_idx == 3'(r)) begin
                col_owner_new[r] = player_q;
            end
        end
    end

    find_vga_row u_find_vga_row (
        .therm_i   (col_therm_new),
        .vga_row_o (new_row)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        onoff_d       = onoff_q;
        owner_d       = owner_q;
        player_d      = player_q;
        count_d       = count_q;
        draw_col_d    = draw_col_q;
        draw_row_d    = draw_row_q;
        draw_player_d = draw_player_q;
        move_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (move_valid) begin
                    col_d   = move_col;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (col_legal) begin
                    state_d = ST_UPDATE;
                end else begin
                    move_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (col_q == 3'(c)) begin
                        onoff_d[c*NUM_ROWS +: NUM_ROWS] = col_therm_new;
                        owner_d[c*NUM_ROWS +: NUM_ROWS] = col_owner_new;
                    end
                end
                draw_col_d    = col_q;
                draw_row_d    = new_row;
                draw_player_d = player_q;
                state_d       = ST_DRAW;
            end
            ST_DRAW: begin
                if (draw_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                player_d = (player_q == PLAYER1) ? PLAYER2 : PLAYER1;
                count_d  = count_q + 6'd1;
                state_d  = (count_d == 6'(MOVES_MAX)) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new game wins over anything the FSM decided this cycle, including a pending draw.
        if (new_game) begin
            state_d    = ST_IDLE;
            onoff_d    = '0;
            owner_d    = '0;
            player_d   = PLAYER1;
            count_d    = '0;
            move_err_d = 1'b0;
        end
    end

    assign draw_req_d   = (state_d == ST_DRAW);
    assign board_full_d = (state_d == ST_FULL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            onoff_q       <= '0;
            owner_q       <= '0;
            player_q      <= PLAYER1;
            count_q       <= '0;
            draw_req_q    <= 1'b0;
            draw_col_q    <= '0;
            draw_row_q    <= '0;
            draw_player_q <= 1'b0;
            move_err_q    <= 1'b0;
            board_full_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            onoff_q       <= onoff_d;
            owner_q       <= owner_d;
            player_q      <= player_d;
            count_q       <= count_d;
            draw_req_q    <= draw_req_d;
            draw_col_q    <= draw_col_d;
            draw_row_q    <= draw_row_d;
            draw_player_q <= draw_player_d;
            move_err_q    <= move_err_d;
            board_full_q  <= board_full_d;
        end
    end

    assign move_ready  = (state_q == ST_IDLE);
    assign move_err    = move_err_q;
    assign draw_req    = draw_req_q;
    assign draw_col    = draw_col_q;
    assign draw_row    = draw_row_q;
    assign draw_player = draw_player_q;
    assign cur_player  = player_q;
    assign board_full  = board_full_q;
    assign onoff_flat  = onoff_q;
    assign owner_flat  = owner_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: a move table plus a fill-the-board run,
// with expected draw/reject outcomes queued at drive time and popped on response.
module tb_drop_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [2:0]  move_col = 3'd0;
    logic        draw_done = 1'b0;
    logic        move_ready, move_err, draw_req, draw_player, cur_player, board_full;
    logic [2:0]  draw_col, draw_row;
    logic [41:0] onoff_flat, owner_flat;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    drop_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_col    (move_col),
        .move_ready  (move_ready),
        .move_err    (move_err),
        .draw_req    (draw_req),
        .draw_col    (draw_col),
        .draw_row    (draw_row),
        .draw_player (draw_player),
        .draw_done   (draw_done),
        .cur_player  (cur_player),
        .board_full  (board_full),
        .onoff_flat  (onoff_flat),
        .owner_flat  (owner_flat)
    );

    typedef struct {
        bit         is_err;
        logic [2:0] col;
        logic [2:0] row;
        logic       player;
    } exp_t;

    typedef struct {
        bit         ng;
        logic [2:0] col;
        int         delay;
        bit         exp_err;
        logic [2:0] exp_row;
        logic       exp_player;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    logic [5:0] m_on[7];
    logic [5:0] m_ow[7];
    logic       m_player;
    int         m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 7; c++) begin
            m_on[c] = '0;
            m_ow[c] = '0;
        end
        m_player = 1'b0;
        m_count  = 0;
    endfunction

    function automatic void model_apply(input int col);
        int n;
        n = $countones(m_on[col]);
        m_ow[col][n] = m_player;
        m_on[col] = {m_on[col][4:0], 1'b1};
        m_player = ~m_player;
        m_count++;
    endfunction

    function automatic exp_t model_expect(input int col);
        exp_t e;
        e.col    = 3'(col);
        e.player = m_player;
        e.is_err = 1'b1;
        e.row    = 3'd0;
        if (col < 7) begin
            e.is_err = m_on[col][5];
            e.row    = 3'(5 - $countones(m_on[col]));
        end
        return e;
    endfunction

    function automatic logic [41:0] flat_on();
        logic [41:0] v;
        for (int c = 0; c < 7; c++) v[c*6 +: 6] = m_on[c];
        return v;
    endfunction

    function automatic logic [41:0] flat_ow();
        logic [41:0] v;
        for (int c = 0; c < 7; c++) v[c*6 +: 6] = m_ow[c];
        return v;
    endfunction

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
    endtask

    task automatic do_move(input int col, input int delay, input exp_t e);
        exp_t got;
        int   waited;
        waited = 0;
        while (!move_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("ready_before_move", move_ready, 1);
        exp_q.push_back(e);
        move_valid = 1'b1;
        move_col   = 3'(col);
        tick();
        move_valid = 1'b0;
        tick();
        got = exp_q.pop_front();
        chk("move_err_at_check", move_err, got.is_err);
        chk("draw_req_not_early", draw_req, 0);
        tick();
        chk("move_err_one_cycle", move_err, 0);
        chk("draw_req_latency", draw_req, !got.is_err);
        if (got.is_err) begin
            chk("ready_after_err", move_ready, 1);
            chk("board_after_err", onoff_flat, flat_on());
            chk("player_after_err", cur_player, m_player);
            return;
        end
        chk("draw_col", draw_col, got.col);
        chk("draw_row", draw_row, got.row);
        chk("draw_player", draw_player, got.player);
        for (int k = 0; k < delay; k++) begin
            move_valid = k[0];
            move_col   = 3'd5;
            tick();
            chk("draw_req_hold", draw_req, 1);
            chk("draw_coords_hold", {draw_col, draw_row, draw_player}, {got.col, got.row, got.player});
        end
        move_valid = 1'b0;
        draw_done  = 1'b1;
        tick();
        draw_done  = 1'b0;
        chk("draw_req_drop", draw_req, 0);
        tick();
        model_apply(col);
        chk("cur_player", cur_player, m_player);
        chk("onoff_map", onoff_flat, flat_on());
        chk("owner_map", owner_flat, flat_ow());
        chk("board_full_flag", board_full, m_count == 42);
        chk("ready_after_move", move_ready, m_count != 42);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        model_clear();
        vecs[0] = '{1'b0, 3'd3, 0,  1'b0, 3'd5, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 0,  1'b0, 3'd5, 1'b0};
        vecs[2] = '{1'b0, 3'd0, 0,  1'b0, 3'd4, 1'b1};
        vecs[3] = '{1'b0, 3'd0, 0,  1'b0, 3'd3, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 0,  1'b0, 3'd2, 1'b1};
        vecs[5] = '{1'b0, 3'd0, 0,  1'b0, 3'd1, 1'b0};
        vecs[6] = '{1'b0, 3'd0, 0,  1'b0, 3'd0, 1'b1};
        vecs[7] = '{1'b0, 3'd0, 0,  1'b1, 3'd0, 1'b0};
        vecs[8] = '{1'b0, 3'd7, 0,  1'b1, 3'd0, 1'b0};
        vecs[9] = '{1'b0, 3'd2, 20, 1'b0, 3'd5, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_move_ready", move_ready, 1);
        chk("rst_draw_req", draw_req, 0);
        chk("rst_move_err", move_err, 0);
        chk("rst_board_full", board_full, 0);
        chk("rst_cur_player", cur_player, 0);
        chk("rst_onoff", onoff_flat, 0);
        chk("rst_owner", owner_flat, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].ng) pulse_new_game();
            e.is_err = vecs[i].exp_err;
            e.col    = vecs[i].col;
            e.row    = vecs[i].exp_row;
            e.player = vecs[i].exp_player;
            do_move(int'(vecs[i].col), vecs[i].delay, e);
            if (i == 0) chk("col3_first_move", onoff_flat[23:18], 6'b000001);
        end
        chk("col0_occupancy", onoff_flat[5:0], 6'b111111);
        chk("col0_owners", owner_flat[5:0], 6'b101010);

        pulse_new_game();
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                do_move(c, (r == 2) ? 3 : 0, model_expect(c));
            end
        end
        chk("full_flag", board_full, 1);
        chk("full_not_ready", move_ready, 0);
        move_valid = 1'b1;
        move_col   = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("full_no_draw", draw_req, 0);
            chk("full_no_err", move_err, 0);
            chk("full_stays", board_full, 1);
        end
        move_valid = 1'b0;

        pulse_new_game();
        chk("ng_board_full", board_full, 0);
        chk("ng_ready", move_ready, 1);
        chk("ng_onoff", onoff_flat, 0);
        chk("ng_owner", owner_flat, 0);
        chk("ng_player", cur_player, 0);

        move_valid = 1'b1;
        move_col   = 3'd2;
        new_game   = 1'b1;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        chk("ng_over_move_ready", move_ready, 1);
        tick();
        tick();
        chk("ng_over_move_no_draw", draw_req, 0);
        chk("ng_over_move_board", onoff_flat, 0);

        do_move(6, 0, model_expect(6));
        move_valid = 1'b1;
        move_col   = 3'd4;
        tick();
        move_valid = 1'b0;
        tick();
        tick();
        chk("abort_in_draw", draw_req, 1);
        draw_done = 1'b1;
        new_game  = 1'b1;
        tick();
        draw_done = 1'b0;
        new_game  = 1'b0;
        model_clear();
        chk("abort_draw_req", draw_req, 0);
        chk("abort_ready", move_ready, 1);
        chk("abort_onoff", onoff_flat, 0);
        chk("abort_owner", owner_flat, 0);
        chk("abort_player", cur_player, 0);
        tick();
        chk("abort_player_stays", cur_player, 0);
        chk("abort_draw_stays_low", draw_req, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
Game-move controller for the Connect Four board. It accepts a column choice from the active player and checks that the column is legal and not full. It then updates the per-column thermometer occupancy and owner maps, sequences one draw request to the VGA renderer, and alternates the turn. It sits between the player-input logic and the VGA draw engine, and is the single writer of the board state.

Parameters:
NUM_COLS, 7, number of board columns
NUM_ROWS, 6, number of board rows; occupancy per column is a NUM_ROWS-bit thermometer, bit 0 = bottom
MOVES_MAX, 42, NUM_COLS*NUM_ROWS; move count at which the board is full

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
new_game  in  1  synchronous clear pulse; highest priority
move_valid  in  1  player move request
move_col  in  3  requested column, 0 = leftmost
move_ready  out  1  high only in IDLE; a move is accepted when move_valid && move_ready
move_err  out  1  one-cycle pulse on rejected move
draw_req  out  1  draw request to the VGA engine
draw_col  out  3  column of the piece to draw
draw_row  out  3  VGA row of the piece; 0 = top, 5 = bottom
draw_player  out  1  owner of the piece (0 = P1, 1 = P2)
draw_done  in  1  VGA engine completion; sampled only in DRAW
cur_player  out  1  player whose turn it is
board_full  out  1  high in FULL
onoff_flat  out  NUM_COLS*NUM_ROWS  occupancy; column c occupies bits [c*NUM_ROWS +: NUM_ROWS]
owner_flat  out  NUM_COLS*NUM_ROWS  owner bit per cell, same layout; valid only where the occupancy bit = 1

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; onoff_flat, owner_flat, cur_player, draw_*, move_err, board_full, and move count all 0. move_ready is combinational from state, so it is 1 after reset.
- States: IDLE, CHECK, UPDATE, DRAW, NEXT, FULL.
- IDLE: when move_valid && move_ready, register move_col and go to CHECK.
- CHECK (1 cycle) rejects the move if col >= NUM_COLS, or if the top bit of the column thermometer is 1:
  - move_err=1 for exactly this cycle's registered output; board unchanged; cur_player unchanged; return to IDLE.
  - Otherwise go to UPDATE.
- UPDATE (1 cycle):
  - Column thermometer becomes {old[NUM_ROWS-2:0],1'b1}.
  - owner bit at the new cell index (popcount of old) is set to cur_player.
  - draw_row is latched from the new thermometer: 1 bit set→5, 2→4, …, 6→0.
  - draw_col and draw_player are latched.
  - Go to DRAW.
- DRAW: draw_req=1 with draw_col, draw_row and draw_player held stable.
  - If draw_done is high in any DRAW cycle, including the first, drop draw_req in the next cycle and go to NEXT.
  - No timeout; the state waits indefinitely.
- NEXT (1 cycle): cur_player toggles; move count increments. If the new count == MOVES_MAX go to FULL, else go to IDLE.
- FULL: board_full=1, move_ready=0; move_valid is ignored. Only new_game or reset exit.
- Latency: accepted move to draw_req high = 3 cycles (CHECK, UPDATE, DRAW entry). draw_done to move_ready high = 2 cycles.
- new_game, in any state:
  - Next cycle: state=IDLE; board, owner map, count, cur_player and board_full cleared; draw_req forced 0.
  - It overrides a simultaneous move_valid or draw_done.
  - A draw aborted by new_game is not completed.
- move_valid outside IDLE is ignored and not queued.
- Every output is registered, except move_ready.

Decomposition:
- Shared package holds:
  - State encoding typedef.
  - NUM_COLS, NUM_ROWS, MOVES_MAX.
  - PLAYER1=1'b0 and PLAYER2=1'b1 constants.
  - Thermometer-index helper function.
- Row decode reuses the team's existing thermometer-to-VGA-row decoder, find_vga_row, instantiated once on the post-update column value.
- No other sub-modules.

Test Plan:
- Reset then single move: move_col=3 → CHECK, UPDATE, draw_req high 3 cycles after accept, with draw_col=3, draw_row=5, draw_player=0. draw_done → cur_player=1, and column 3 occupancy = 6'b000001.
- Stack column 0 six times, alternating players, with draw_done returned on the first DRAW cycle → draw_row sequence 5,4,3,2,1,0. Occupancy = 6'b111111; owner bits = 6'b101010.
- Seventh move to full column 0, and a separate move with move_col=7 → move_err one-cycle pulse each time, no draw_req, cur_player and board unchanged.
- draw_done delayed 20 cycles → draw_req and coordinates held stable throughout; move_valid pulses during that time are ignored.
- Fill all 42 cells → board_full=1 and move_ready=0 after the last NEXT. Later move_valid gives no response. new_game → all state cleared and move_ready=1.
- new_game asserted mid-DRAW together with draw_done → draw_req=0 next cycle, IDLE, board cleared, cur_player=0.
